// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA timing generator.
// Divides the 50 MHz clk into a 25 MHz pixel strobe. Runs the horizontal and
// vertical counters and drives registered sync, blanking and pixel coordinates
// to the renderers. Also issues a one-clk frame tick at vertical-blank start.
// Optional feature macro: VGA_TEST_PATTERN_EN adds the test_color[23:0]
// output, which shows eight vertical colour bars.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   output logic       vga_clk,
   output logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       active_pixels,
   output logic [9:0] xPixel,
   output logic [9:0] yPixel,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic       frame_tick
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [23:0] test_color
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 10-bit forms of the timing boundaries, fixed at elaboration
   localparam logic [9:0] H_ACT_L    = 10'(H_ACTIVE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_L    = 10'(V_ACTIVE);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;

   logic       h_act;
   logic       act_d;
   logic       hs_d;
   logic       vs_d;
   logic       tick_d;
   logic [9:0] x_d;
   logic [9:0] y_d;

   // Pixel strobe: toggles every clk, so it is high on every second edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pix_en <= 1'b0;
      else      pix_en <= ~pix_en;
   end

   // Pixel clock to the DAC: rises on the clk edge after the outputs change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vga_clk <= 1'b0;
      else      vga_clk <= ~pix_en;
   end

   // Horizontal and vertical counters, advancing once per pixel
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) v_cnt <= '0;
            else                 v_cnt <= v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Decode of the current counter position into next output values
   always_comb begin
      h_act  = 1'b0;
      act_d  = 1'b0;
      hs_d   = 1'b1;
      vs_d   = 1'b1;
      tick_d = 1'b0;
      x_d    = '0;
      y_d    = '0;
      h_act  = (h_cnt < H_ACT_L);
      act_d  = h_act && (v_cnt < V_ACT_L);
      hs_d   = !((h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END));
      vs_d   = !((v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END));
      tick_d = (h_cnt == '0) && (v_cnt == V_ACT_L);
      if (act_d) begin
         x_d = h_cnt;
         y_d = v_cnt;
      end
   end

   // Registered timing outputs, one pixel period behind the counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync         <= 1'b1;
         vsync         <= 1'b1;
         active_pixels <= 1'b0;
         xPixel        <= '0;
         yPixel        <= '0;
      end else if (pix_en) begin
         hsync         <= hs_d;
         vsync         <= vs_d;
         active_pixels <= act_d;
         xPixel        <= x_d;
         yPixel        <= y_d;
      end
   end

   // Frame tick: loaded every clk so it lasts exactly one clk
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) frame_tick <= 1'b0;
      else      frame_tick <= pix_en & tick_d;
   end

   assign VGA_BLANK_N = active_pixels;
   assign VGA_SYNC_N  = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);

   logic [2:0]  bar_idx;
   logic [9:0]  bar_px;
   logic [23:0] bar_color;
   logic [23:0] color_d;

   // Bar index: counts bar widths across the visible part of a line,
   // cleared at line wrap so every line starts at bar 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bar_idx <= '0;
         bar_px  <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            bar_idx <= '0;
            bar_px  <= '0;
         end else if (h_act) begin
            if (bar_px == BAR_LAST) begin
               bar_px  <= '0;
               bar_idx <= bar_idx + 3'd1;
            end else begin
               bar_px <= bar_px + 10'd1;
            end
         end
      end
   end

   // Colour lookup for the current bar, black outside the visible region
   always_comb begin
      bar_color = '0;
      color_d   = '0;
      case (bar_idx)
         3'd0:    bar_color = 24'hFFFFFF;
         3'd1:    bar_color = 24'hFFFF00;
         3'd2:    bar_color = 24'h00FFFF;
         3'd3:    bar_color = 24'h00FF00;
         3'd4:    bar_color = 24'hFF00FF;
         3'd5:    bar_color = 24'hFF0000;
         3'd6:    bar_color = 24'h0000FF;
         default: bar_color = 24'h000000;
      endcase
      if (act_d) color_d = bar_color;
   end

   // Registered test colour, aligned with the other timing outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        test_color <= '0;
      else if (pix_en) test_color <= color_d;
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// A default 640x480 instance covers line-level timing. A second instance with
// small timing parameters covers frame-level behaviour within a short run.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #10 clk = ~clk;

   logic       d_vga_clk, d_pix_en, d_hsync, d_vsync, d_active, d_blank_n, d_sync_n, d_tick;
   logic [9:0] d_x, d_y;
   logic       s_vga_clk, s_pix_en, s_hsync, s_vsync, s_active, s_blank_n, s_sync_n, s_tick;
   logic [9:0] s_x, s_y;
`ifdef VGA_TEST_PATTERN_EN
   logic [23:0] d_tc, s_tc;
`endif

   vga_timing_gen dut (
      .clk(clk), .rst(rst), .vga_clk(d_vga_clk), .pix_en(d_pix_en),
      .hsync(d_hsync), .vsync(d_vsync), .active_pixels(d_active),
      .xPixel(d_x), .yPixel(d_y), .VGA_BLANK_N(d_blank_n),
      .VGA_SYNC_N(d_sync_n), .frame_tick(d_tick)
`ifdef VGA_TEST_PATTERN_EN
      , .test_color(d_tc)
`endif
   );

   // Small frame: H_TOTAL=16 (sync 10..12), V_TOTAL=10 (sync 7..8)
   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_s (
      .clk(clk), .rst(rst), .vga_clk(s_vga_clk), .pix_en(s_pix_en),
      .hsync(s_hsync), .vsync(s_vsync), .active_pixels(s_active),
      .xPixel(s_x), .yPixel(s_y), .VGA_BLANK_N(s_blank_n),
      .VGA_SYNC_N(s_sync_n), .frame_tick(s_tick)
`ifdef VGA_TEST_PATTERN_EN
      , .test_color(s_tc)
`endif
   );

   // n = clk edges since reset release; exp = {pix_en,hsync,vsync,active,tick,x,y}
   typedef struct {
      logic        sel;
      int unsigned n;
      logic [24:0] exp;
   } vec_t;

   typedef struct {
      logic        sel;
      int unsigned n;
      logic [23:0] color;
   } tp_t;

   vec_t vecs[$];
   tp_t  tps[$];

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned n;
   int unsigned inv_err, d_hs_low, d_act_hi, d_hs_first, s_ticks, s_tick1, s_tick2, s_vs_low;

   function automatic vec_t mk(input logic sel, input int unsigned cyc, input logic hs,
                               input logic vs, input logic a, input logic t,
                               input logic [9:0] x, input logic [9:0] y);
      vec_t v;
      v.sel = sel;
      v.n   = cyc;
      v.exp = {(cyc % 2 == 1), hs, vs, a, t, x, y};
      return v;
   endfunction

   function automatic tp_t mt(input logic sel, input int unsigned cyc, input logic [23:0] c);
      tp_t t;
      t.sel = sel;
      t.n = cyc;
      t.color = c;
      return t;
   endfunction

   function automatic logic [24:0] got(input logic sel);
      if (sel) return {s_pix_en, s_hsync, s_vsync, s_active, s_tick, s_x, s_y};
      return {d_pix_en, d_hsync, d_vsync, d_active, d_tick, d_x, d_y};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " dflt"}, 32'({got(1'b0), d_vga_clk, d_blank_n, d_sync_n}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000}));
      chk({tag, " small"}, 32'({got(1'b1), s_vga_clk, s_blank_n, s_sync_n}),
          32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 3'b000}));
`ifdef VGA_TEST_PATTERN_EN
      chk({tag, " test_color"}, 32'({d_tc, s_tc}), 32'(48'h0));
`endif
   endtask

   // Run `last` clk edges after release, applying table entries and invariants
   task automatic run_phase(input int unsigned last);
      inv_err = 0; d_hs_low = 0; d_act_hi = 0; d_hs_first = 0;
      s_ticks = 0; s_tick1 = 0; s_tick2 = 0; s_vs_low = 0;
      n = 0;
      while (n < last) begin
         @(posedge clk);
         n++;
         #1;
         foreach (vecs[i])
            if (vecs[i].n == n)
               chk($sformatf("vec %s n=%0d", vecs[i].sel ? "small" : "dflt", n),
                   32'(got(vecs[i].sel)), 32'(vecs[i].exp));
`ifdef VGA_TEST_PATTERN_EN
         foreach (tps[i])
            if (tps[i].n == n)
               chk($sformatf("color %s n=%0d", tps[i].sel ? "small" : "dflt", n),
                   32'(tps[i].sel ? s_tc : d_tc), 32'(tps[i].color));
`endif
         if (d_blank_n !== d_active || s_blank_n !== s_active) inv_err++;
         if (d_sync_n !== 1'b0 || s_sync_n !== 1'b0) inv_err++;
         if (!d_active && (d_x != 10'd0 || d_y != 10'd0)) inv_err++;
         if (!s_active && (s_x != 10'd0 || s_y != 10'd0)) inv_err++;
         if (d_pix_en !== (n % 2 == 1) || s_pix_en !== (n % 2 == 1)) inv_err++;
         if (d_vga_clk !== (n % 2 == 1) || s_vga_clk !== (n % 2 == 1)) inv_err++;
         if (d_tick !== 1'b0) inv_err++;
         if (n <= 1601) begin
            if (!d_hsync) d_hs_low++;
            if (d_active) d_act_hi++;
            if (!d_hsync && d_hs_first == 0) d_hs_first = n;
         end
         if (n <= 321 && !s_vsync) s_vs_low++;
         if (n <= 660 && s_tick) begin
            s_ticks++;
            if (s_ticks == 1) s_tick1 = n;
            if (s_ticks == 2) s_tick2 = n;
         end
      end
   endtask

   task automatic check_measure(input string tag);
      chk({tag, " invariants violations"}, inv_err, 0);
      chk({tag, " hsync low clks"}, d_hs_low, 192);
      chk({tag, " active clks in line"}, d_act_hi, 1280);
      chk({tag, " hsync start after x0"}, d_hs_first - 2, 1312);
      chk({tag, " small vsync low clks"}, s_vs_low, 64);
      chk({tag, " small frame ticks"}, s_ticks, 2);
      chk({tag, " small tick after x0y0"}, s_tick1 - 2, 192);
      chk({tag, " small frame period"}, s_tick2 - s_tick1, 320);
   endtask

   initial begin
      // Default instance: pixel p shows after edges 2p+2 and 2p+3
      vecs.push_back(mk(0, 1,    1, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 2,    1, 1, 1, 0, 0,   0));
      vecs.push_back(mk(0, 3,    1, 1, 1, 0, 0,   0));
      vecs.push_back(mk(0, 4,    1, 1, 1, 0, 1,   0));
      vecs.push_back(mk(0, 108,  1, 1, 1, 0, 53,  0));
      vecs.push_back(mk(0, 1281, 1, 1, 1, 0, 639, 0));
      vecs.push_back(mk(0, 1282, 1, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 1313, 1, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 1314, 0, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 1505, 0, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 1506, 1, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 1601, 1, 1, 0, 0, 0,   0));
      vecs.push_back(mk(0, 1602, 1, 1, 1, 0, 0,   1));
      vecs.push_back(mk(0, 1604, 1, 1, 1, 0, 1,   1));
      // Small instance: h = p%16, v = (p/16)%10
      vecs.push_back(mk(1, 2,   1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 16,  1, 1, 1, 0, 7, 0));
      vecs.push_back(mk(1, 18,  1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 22,  0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 27,  0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 28,  1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 34,  1, 1, 1, 0, 0, 1));
      vecs.push_back(mk(1, 108, 1, 1, 1, 0, 5, 3));
      vecs.push_back(mk(1, 176, 1, 1, 1, 0, 7, 5));
      vecs.push_back(mk(1, 193, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 194, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 195, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 226, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 257, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 290, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 322, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 514, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 515, 1, 1, 0, 0, 0, 0));
      // Colour bars: 80 px wide by default, 1 px wide in the small instance
      tps.push_back(mt(0, 2,    24'hFFFFFF));
      tps.push_back(mt(0, 160,  24'hFFFFFF));
      tps.push_back(mt(0, 162,  24'hFFFF00));
      tps.push_back(mt(0, 1120, 24'h0000FF));
      tps.push_back(mt(0, 1122, 24'h000000));
      tps.push_back(mt(0, 1281, 24'h000000));
      tps.push_back(mt(0, 1282, 24'h000000));
      tps.push_back(mt(1, 2,    24'hFFFFFF));
      tps.push_back(mt(1, 4,    24'hFFFF00));
      tps.push_back(mt(1, 6,    24'h00FFFF));
      tps.push_back(mt(1, 16,   24'h000000));
      tps.push_back(mt(1, 18,   24'h000000));
      tps.push_back(mt(1, 34,   24'hFFFFFF));
      tps.push_back(mt(1, 36,   24'hFFFF00));

      // Power-on reset
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk) rst = 1'b1;
      run_phase(1700);
      check_measure("run1");

      // Mid-frame asynchronous reset (small instance at h=5, v=3)
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      run_phase(108);
      #4 rst = 1'b0;
      #1;
      check_reset("async reset");
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset held");
      @(negedge clk) rst = 1'b1;
      run_phase(1700);
      check_measure("after reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the paddle/ball/brick renderers.
- Divides the 50 MHz clk into a 25 MHz pixel clock enable.
- Runs 640x480@60 horizontal and vertical counters, and drives hsync, vsync, blanking, the pixel coordinates and active_pixels to every renderer.
- Also issues a once-per-frame tick at vertical-blank start, so game logic can update positions outside the active region.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous, active-low reset
- vga_clk  out  1  25 MHz pixel clock to DAC
- pix_en  out  1  one-clk-wide pixel strobe, high every 2nd clk
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- active_pixels  out  1  high inside the 640x480 visible region
- xPixel  out  10  column, 0..639 when active, 0 otherwise
- yPixel  out  10  row, 0..479 when active, 0 otherwise
- VGA_BLANK_N  out  1  equals active_pixels
- VGA_SYNC_N  out  1  constant 0
- frame_tick  out  1  one-clk pulse at vertical-blank start

Behaviour:
- Reset state (asynchronous, active-low): pix_en=0, vga_clk=0, h_cnt=0, v_cnt=0, hsync=1, vsync=1, active_pixels=0, xPixel=0, yPixel=0, frame_tick=0.
- pix_en: register toggles every clk. vga_clk mirrors the inverse phase, so each rising edge of vga_clk sits one clk after the outputs change.
- All timing outputs are registered and update only on clk edges where pix_en=1. On such an edge:
  - outputs take the decode of the current (h_cnt, v_cnt);
  - the counters then advance.
  - Result: one pixel-period latency from counter to output.
- Counters, with H_TOTAL = 800 and V_TOTAL = 525 by default:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments only on h_cnt wrap, and wraps 524 -> 0.
- hsync = 0 iff h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
- vsync = 0 iff v_cnt in [490, 491].
- active_pixels = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- xPixel/yPixel = h_cnt/v_cnt when active, else forced to 0.
- frame_tick: high for exactly one clk on the pix_en edge that decodes (h_cnt=0, v_cnt=V_ACTIVE). This is once per 840000 clk.
- Width rules:
  - Counters are 10 bits.
  - Parameter sums are evaluated at elaboration.
  - Totals must not exceed 1024; out-of-range values are unsupported.
- First output after reset: pixel (0,0) appears after the 2nd clk edge following rst release. No partial or garbage frame is emitted.
- Reset asserted mid-frame: all state returns to reset values immediately. The frame restarts from (0,0) on release.
- Counters free-run and have no external enable.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - An extra output test_color[23:0] is present, registered on pix_en edges with the other outputs.
  - It shows 8 vertical colour bars, each 80 pixels wide, in this order from x=0: white, yellow, cyan, green, magenta, red, blue, black.
  - It is 0 outside the active region.
  - The bar index comes from a 0..7 counter that advances every 80 active pixels and clears at the start of each line. No divider is used.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then release -> outputs match reset values; active_pixels first rises on the 2nd clk edge after release, with xPixel=0, yPixel=0; pix_en toggles every clk.
- Run one full line -> hsync low for exactly 192 clk (96 pixels), starting 1312 clk after xPixel=0; line period is 1600 clk; active_pixels high for 1280 clk.
- Run two frames -> vsync low for exactly 3200 clk per frame; frame period 840000 clk; frame_tick pulses once per frame, exactly 768000 clk after active (0,0).
- Scan all active pixels -> xPixel reaches 639 and yPixel reaches 479; both read 0 whenever active_pixels=0; VGA_BLANK_N == active_pixels at every clk; VGA_SYNC_N == 0.
- Assert rst at h_cnt=400, v_cnt=300, hold 3 clk, release -> outputs return to reset values asynchronously; the next frame starts at (0,0) with correct timing.
- With VGA_TEST_PATTERN_EN defined -> test_color = 24'hFFFFFF at x=0..79, 24'hFFFF00 at x=80..159, 24'h000000 at x=560..639 and during blanking.
